// File: rtl/collision_engine_if.sv
// Bundle of the collision engine's stimulus inputs and its report/status outputs.
// master drives the game state, slave is the engine.
interface collision_engine_if #(
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int NUM_ENEMIES = 4,
    parameter int SCORE_W     = 16
);
    logic                       enable;
    logic [GRID_W*GRID_H-1:0]   grid;
    logic [7:0]                 user_x;
    logic [6:0]                 user_y;
    logic [8*NUM_ENEMIES-1:0]   enemy_x;
    logic [7*NUM_ENEMIES-1:0]   enemy_y;
    logic [NUM_ENEMIES-1:0]     enemy_alive;
    logic [NUM_ENEMIES-1:0]     enemy_hit;
    logic                       current_score_update;
    logic                       current_health_update;
    logic [SCORE_W-1:0]         score;
    logic                       busy;
    logic                       overrun;

    modport master (
        output enable, grid, user_x, user_y, enemy_x, enemy_y, enemy_alive,
        input  enemy_hit, current_score_update, current_health_update, score, busy, overrun
    );
    modport slave (
        input  enable, grid, user_x, user_y, enemy_x, enemy_y, enemy_alive,
        output enemy_hit, current_score_update, current_health_update, score, busy, overrun
    );
endinterface

// File: rtl/collision_engine.sv
// Per-frame collision scan: on each enabled tick, snapshot the game state and test one
// enemy per cycle against the bullet grid and the player, then pulse a one-cycle report.
module collision_engine #(
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int NUM_ENEMIES = 4,
    parameter int TICK_COUNT  = 1_499_999,
    parameter int SCORE_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    collision_engine_if.slave  bus
);
    localparam int PIX   = GRID_W * GRID_H;
    localparam int PIX_W = $clog2(PIX);
    localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int DIV_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
    localparam int SUM_W = SCORE_W + 5;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DIV_W-1:0]         div_q;
    logic [IDX_W-1:0]         idx_q;
    logic [PIX-1:0]           grid_q;
    logic [7:0]               ux_q;
    logic [6:0]               uy_q;
    logic [8*NUM_ENEMIES-1:0] ex_q;
    logic [7*NUM_ENEMIES-1:0] ey_q;
    logic [NUM_ENEMIES-1:0]   alive_q;
    logic [NUM_ENEMIES-1:0]   hit_q;
    logic                     coll_q;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic                     overrun_q;

    logic             tick, start, last;
    logic [7:0]       cur_x;
    logic [6:0]       cur_y;
    logic             cur_alive, in_range, hit_now, coll_now;
    logic [PIX_W-1:0] pix_idx;
    logic [4:0]       hit_cnt;
    logic [SUM_W-1:0] sum;

    assign tick  = (div_q == '0);
    assign start = (state_q == S_IDLE) && tick && bus.enable;
    assign last  = (idx_q == IDX_W'(NUM_ENEMIES - 1));

    // Free-running tick divider, independent of enable and FSM state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) div_q <= DIV_W'(TICK_COUNT);
        else       div_q <= tick ? DIV_W'(TICK_COUNT) : div_q - 1'b1;
    end

    // Current enemy under test; out-of-range coordinates force index 0 and mask the bit.
    always_comb begin
        cur_x     = ex_q[8*int'(idx_q) +: 8];
        cur_y     = ey_q[7*int'(idx_q) +: 7];
        cur_alive = alive_q[idx_q];
        in_range  = (32'(cur_x) < GRID_W) && (32'(cur_y) < GRID_H);
        pix_idx   = in_range ? PIX_W'(32'(cur_x) * GRID_H + 32'(cur_y)) : '0;
        hit_now   = cur_alive && in_range && grid_q[pix_idx];
        coll_now  = cur_alive && (cur_x == ux_q) && (cur_y == uy_q);
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) hit_cnt = hit_cnt + 5'(hit_q[i]);
        sum     = SUM_W'(score_q) + SUM_W'(hit_cnt);
        score_d = (sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SCAN;
            S_SCAN:   if (last)  state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            grid_q    <= '0;
            ux_q      <= '0;
            uy_q      <= '0;
            ex_q      <= '0;
            ey_q      <= '0;
            alive_q   <= '0;
            hit_q     <= '0;
            coll_q    <= 1'b0;
            score_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: if (start) begin
                    grid_q  <= bus.grid;
                    ux_q    <= bus.user_x;
                    uy_q    <= bus.user_y;
                    ex_q    <= bus.enemy_x;
                    ey_q    <= bus.enemy_y;
                    alive_q <= bus.enemy_alive;
                    idx_q   <= '0;
                    hit_q   <= '0;
                    coll_q  <= 1'b0;
                end
                S_SCAN: begin
                    hit_q[idx_q] <= hit_now;
                    coll_q       <= coll_q | coll_now;
                    if (!last) idx_q <= idx_q + 1'b1;
                end
                S_REPORT: begin
                    score_q <= score_d;
                    idx_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.enemy_hit             = (state_q == S_REPORT) ? hit_q : '0;
    assign bus.current_score_update  = (state_q == S_REPORT) && (|hit_q);
    assign bus.current_health_update = (state_q == S_REPORT) && coll_q;
    assign bus.score                 = score_q;
    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.overrun               = overrun_q;
endmodule

// File: tb/tb_collision_engine.sv
// Randomised and directed checks of collision_engine against a frame-level reference model.
module tb_collision_engine;
    localparam int N  = 4;
    localparam int GW = 160;
    localparam int GH = 120;
    localparam int TC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    collision_engine_if #(.GRID_W(GW), .GRID_H(GH), .NUM_ENEMIES(N), .SCORE_W(16)) ifa();
    collision_engine_if #(.GRID_W(GW), .GRID_H(GH), .NUM_ENEMIES(N), .SCORE_W(2))  ifs();

    collision_engine #(.GRID_W(GW), .GRID_H(GH), .NUM_ENEMIES(N), .TICK_COUNT(TC), .SCORE_W(16))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    collision_engine #(.GRID_W(GW), .GRID_H(GH), .NUM_ENEMIES(N), .TICK_COUNT(TC), .SCORE_W(2))
        dut_s (.clk_i(clk), .rst_i(rst), .bus(ifs));

    assign ifs.enable      = ifa.enable;
    assign ifs.grid        = ifa.grid;
    assign ifs.user_x      = ifa.user_x;
    assign ifs.user_y      = ifa.user_y;
    assign ifs.enemy_x     = ifa.enemy_x;
    assign ifs.enemy_y     = ifa.enemy_y;
    assign ifs.enemy_alive = ifa.enemy_alive;

    int total = 0;
    int bad   = 0;
    int cyc;
    int exp_a, exp_s;

    // Clock edges since reset release; a tick is consumed on every edge where cyc becomes a multiple of TC+1.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    logic [GW*GH-1:0] g;
    logic [7:0]       ex [N];
    logic [6:0]       ey [N];
    logic [N-1:0]     alive;
    logic [7:0]       ux;
    logic [6:0]       uy;

    task automatic apply();
        ifa.grid        = g;
        ifa.user_x      = ux;
        ifa.user_y      = uy;
        ifa.enemy_alive = alive;
        for (int i = 0; i < N; i++) begin
            ifa.enemy_x[8*i +: 8] = ex[i];
            ifa.enemy_y[7*i +: 7] = ey[i];
        end
    endtask

    task automatic clear_stim();
        g = '0; alive = '0; ux = '0; uy = '0;
        for (int i = 0; i < N; i++) begin ex[i] = '0; ey[i] = '0; end
        apply();
    endtask

    task automatic randomize_stim();
        g = '0;
        for (int k = 0; k < 40; k++) g[$urandom_range(0, GW*GH-1)] = 1'b1;
        alive = N'($urandom);
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'($urandom_range(0, 175));
            ey[i] = 7'($urandom_range(0, 127));
            if (ex[i] < GW && ey[i] < GH && $urandom_range(0, 1) == 1) g[GH*ex[i] + ey[i]] = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
            int j = $urandom_range(0, N-1);
            ux = ex[j]; uy = ey[j];
        end else begin
            ux = 8'($urandom_range(0, 255)); uy = 7'($urandom_range(0, 127));
        end
        apply();
    endtask

    // Frame outcome straight from the hit/collision rules.
    task automatic model(output logic [N-1:0] h, output logic c);
        h = '0; c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (alive[i] && ex[i] < GW && ey[i] < GH)
                if (g[GH*ex[i] + ey[i]]) h[i] = 1'b1;
            if (alive[i] && ex[i] == ux && ey[i] == uy) c = 1'b1;
        end
    endtask

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic do_reset();
        ifa.enable = 1'b0;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_a = 0; exp_s = 0;
    endtask

    task automatic wait_pre_tick(input string name);
        int k = 0;
        while (cyc % (TC+1) != TC && k < 20) begin @(negedge clk); k++; end
        total++;
        if (k >= 20) begin bad++; $display("FAIL %s tick_align: timed out, cyc=%0d", name, cyc); end
    endtask

    task automatic run_frame(input string name, input bit perturb);
        logic [N-1:0] eh;
        logic ec;
        bit quiet = 1'b1;
        int pc;
        wait_pre_tick(name);
        model(eh, ec);
        ifa.enable = 1'b1;
        @(negedge clk);
        ifa.enable = 1'b0;
        total++;
        if (ifa.busy !== 1'b1) begin bad++; $display("FAIL %s busy_start: got %b want 1", name, ifa.busy); end
        if (perturb) randomize_stim();
        for (int j = 0; j < N-1; j++) begin
            @(negedge clk);
            if (ifa.enemy_hit !== '0 || ifa.current_score_update !== 1'b0 || ifa.current_health_update !== 1'b0)
                quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL %s early_pulse: got a report before T+%0d, want none", name, N+1); end
        @(negedge clk);
        total++;
        if (ifa.enemy_hit !== eh) begin bad++; $display("FAIL %s enemy_hit: got %b want %b", name, ifa.enemy_hit, eh); end
        total++;
        if (ifa.current_score_update !== (|eh)) begin bad++; $display("FAIL %s score_update: got %b want %b", name, ifa.current_score_update, |eh); end
        total++;
        if (ifa.current_health_update !== ec) begin bad++; $display("FAIL %s health_update: got %b want %b", name, ifa.current_health_update, ec); end
        total++;
        if (ifs.enemy_hit !== eh) begin bad++; $display("FAIL %s sat_enemy_hit: got %b want %b", name, ifs.enemy_hit, eh); end
        pc = $countones(eh);
        exp_a = sat(exp_a + pc, 65535);
        exp_s = sat(exp_s + pc, 3);
        @(negedge clk);
        total++;
        if (ifa.score !== 16'(exp_a)) begin bad++; $display("FAIL %s score: got %0d want %0d", name, ifa.score, exp_a); end
        total++;
        if (ifs.score !== 2'(exp_s)) begin bad++; $display("FAIL %s sat_score: got %0d want %0d", name, ifs.score, exp_s); end
        total++;
        if (ifa.busy !== 1'b0 || ifa.current_score_update !== 1'b0 || ifa.enemy_hit !== '0)
            begin bad++; $display("FAIL %s post_report: busy=%b pulse=%b hit=%b want 0", name, ifa.busy, ifa.current_score_update, ifa.enemy_hit); end
    endtask

    task automatic test_reset();
        ifa.enable = 1'b0;
        clear_stim();
        #1 rst = 1'b1;
        #1;
        total++;
        if (ifa.enemy_hit !== '0 || ifa.current_score_update !== 1'b0 || ifa.current_health_update !== 1'b0 ||
            ifa.score !== '0 || ifa.busy !== 1'b0 || ifa.overrun !== 1'b0)
            begin bad++; $display("FAIL reset_async: hit=%b su=%b hu=%b score=%0d busy=%b ovr=%b want all 0",
                ifa.enemy_hit, ifa.current_score_update, ifa.current_health_update, ifa.score, ifa.busy, ifa.overrun); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_a = 0; exp_s = 0;
    endtask

    task automatic test_disabled_idle();
        bit stayed = 1'b1;
        ifa.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifa.busy !== 1'b0 || ifa.overrun !== 1'b0) stayed = 1'b0;
        end
        total++;
        if (!stayed) begin bad++; $display("FAIL disabled_idle: busy/overrun rose with enable=0, want both 0"); end
    endtask

    task automatic test_single_hit();
        clear_stim();
        g[GH*10 + 20] = 1'b1;
        ex[2] = 8'd10; ey[2] = 7'd20; alive = 4'b0100;
        apply();
        run_frame("single_hit", 1'b0);
    endtask

    task automatic test_dead_and_oor();
        clear_stim();
        g[GH*5 + 5] = 1'b1;
        ex[0] = 8'd5;   ey[0] = 7'd5;
        ex[1] = 8'd200; ey[1] = 7'd5;
        g[GH*11 + 5] = 1'b1;
        ex[2] = 8'd10;  ey[2] = 7'd125;
        alive = 4'b0110;
        ux = 8'd99; uy = 7'd99;
        apply();
        run_frame("dead_oor", 1'b0);
    endtask

    task automatic test_player();
        clear_stim();
        ux = 8'd50; uy = 7'd60;
        ex[3] = 8'd50; ey[3] = 7'd60; alive = 4'b1000;
        apply();
        run_frame("player", 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        clear_stim();
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'(20 + 7*i); ey[i] = 7'(30 + 3*i);
            g[GH*ex[i] + ey[i]] = 1'b1;
        end
        alive = '1;
        ux = 8'd150; uy = 7'd1;
        apply();
        run_frame("sat_1", 1'b0);
        run_frame("sat_2", 1'b0);
    endtask

    task automatic test_overrun_snapshot();
        do_reset();
        total++;
        if (ifa.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", ifa.overrun); end
        clear_stim();
        ex[1] = 8'd70; ey[1] = 7'd40; g[GH*70 + 40] = 1'b1;
        ex[0] = 8'd70; ey[0] = 7'd41;
        alive = 4'b0011;
        apply();
        run_frame("snapshot", 1'b1);
        total++;
        if (ifa.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", ifa.overrun); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            randomize_stim();
            run_frame($sformatf("random_%0d", f), 1'b1);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit quiet = 1'b1;
        clear_stim();
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'(5*i); ey[i] = 7'(i); g[GH*ex[i] + ey[i]] = 1'b1;
        end
        alive = '1;
        apply();
        wait_pre_tick("reset_mid");
        ifa.enable = 1'b1;
        @(negedge clk);
        ifa.enable = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (ifa.enemy_hit !== '0 || ifa.current_score_update !== 1'b0 || ifa.current_health_update !== 1'b0 ||
            ifa.score !== '0 || ifa.busy !== 1'b0 || ifa.overrun !== 1'b0)
            begin bad++; $display("FAIL reset_mid: hit=%b su=%b hu=%b score=%0d busy=%b ovr=%b want all 0",
                ifa.enemy_hit, ifa.current_score_update, ifa.current_health_update, ifa.score, ifa.busy, ifa.overrun); end
        @(negedge clk);
        rst = 1'b0;
        ifa.enable = 1'b1;
        for (int k = 0; k < TC; k++) begin
            @(negedge clk);
            if (ifa.busy !== 1'b0 || ifa.current_score_update !== 1'b0 || ifa.current_health_update !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL reset_release_quiet: activity before tick %0d, want none", TC+1); end
        @(negedge clk);
        ifa.enable = 1'b0;
        total++;
        if (ifa.busy !== 1'b1) begin bad++; $display("FAIL first_tick: busy=%b at clock %0d after release, want 1", ifa.busy, TC+1); end
    endtask

    initial begin
        test_reset();
        test_disabled_idle();
        test_single_hit();
        test_dead_and_oor();
        test_player();
        test_saturation();
        test_overrun_snapshot();
        test_random();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 Parameter GRID_W, default 160: grid width in pixels.
REQ-002 Parameter GRID_H, default 120: grid height in pixels.
REQ-003 Parameter NUM_ENEMIES, default 4: enemy channels scanned per frame, range 1..16.
REQ-004 Parameter TICK_COUNT, default 1_499_999: internal tick divider start value.
REQ-005 Parameter SCORE_W, default 16: score counter width.
REQ-006 Port clock, input, 1: single system clock, rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port enable, input, 1: when 1, ticks start scans; when 0, ticks are ignored.
REQ-009 Port grid, input, GRID_W*GRID_H: bullet layer, pixel (x,y) at bit GRID_H*x+y.
REQ-010 Port user_x, input, 8, and port user_y, input, 7: player position.
REQ-011 Port enemy_x, input, 8*NUM_ENEMIES: enemy i occupies bits [8i+7:8i].
REQ-012 Port enemy_y, input, 7*NUM_ENEMIES: enemy i occupies bits [7i+6:7i].
REQ-013 Port enemy_alive, input, NUM_ENEMIES: bit i set means enemy i participates.
REQ-014 Port enemy_hit, output, NUM_ENEMIES: per-enemy hit flags, valid only during the report pulse.
REQ-015 Port current_score_update, output, 1: one-cycle pulse when any enemy is hit in a frame.
REQ-016 Port current_health_update, output, 1: one-cycle pulse when the player overlaps any alive enemy.
REQ-017 Port score, output, SCORE_W: saturating accumulated hit count.
REQ-018 Port busy, output, 1: high while a scan is in progress.
REQ-019 Port overrun, output, 1: sticky flag, set when a tick arrives while busy.

Function
REQ-020 The divider shall load TICK_COUNT, decrement each clock, and reload on reaching 0. A one-cycle tick occurs when the value is 0, regardless of enable.
REQ-021 The FSM shall have the states IDLE, SCAN, REPORT.
REQ-022 IDLE -> SCAN on tick with enable=1. On the same edge, all positions, enemy_alive and grid are latched into snapshot registers, the scan index is cleared to 0, and busy is set.
REQ-023 In SCAN, one enemy index i shall be evaluated per cycle, from 0 to NUM_ENEMIES-1. After the last index the FSM enters REPORT; the scan takes exactly NUM_ENEMIES cycles.
REQ-024 Enemy i is hit when all of the following hold: it is alive, x<GRID_W, y<GRID_H, and the snapshot grid bit GRID_H*x+y is 1.
REQ-025 The player collides with enemy i when enemy i is alive and its (x,y) equals (user_x,user_y) from the snapshot.
REQ-026 Out-of-range coordinates (x>=GRID_W or y>=GRID_H) shall never produce a grid hit and shall not index out of bounds.
REQ-027 In REPORT, for exactly one cycle:
- enemy_hit presents the accumulated flags;
- current_score_update equals the OR of enemy_hit;
- current_health_update equals the OR of player collisions.
REQ-028 On the REPORT cycle, score shall increase by popcount(enemy_hit) and saturate at 2^SCORE_W-1.
REQ-029 REPORT -> IDLE unconditionally; busy clears on entry to IDLE. Outside REPORT, enemy_hit and both update pulses shall be 0.
REQ-030 Latency: a tick at cycle T produces the report pulse at cycle T+NUM_ENEMIES+1.
REQ-031 A tick while in SCAN or REPORT shall be dropped and shall set overrun; the scan in progress shall not be disturbed.
REQ-032 Input changes during SCAN shall not affect the result; only the snapshot is used.
REQ-033 enable falling during SCAN shall not abort the scan in progress.

Reset
REQ-034 While reset=1, the following shall hold immediately, without waiting for a clock:
- FSM in IDLE; divider = TICK_COUNT; scan index = 0;
- score = 0; enemy_hit = 0; both pulses = 0; busy = 0; overrun = 0; snapshot cleared.
REQ-035 Reset asserted mid-scan shall abandon the scan with no report pulse and no score change.
REQ-036 After reset deasserts, the first tick shall occur TICK_COUNT+1 clocks later.

Verification (TICK_COUNT=3, NUM_ENEMIES=4 unless stated)
REQ-037 Single hit:
- Stimulus: grid bit 120*10+20 = 1; enemy 2 at (10,20), alive.
- Response: enemy_hit=4'b0100; score_update pulses once at T+5; score 0->1.
REQ-038 Dead and out-of-range enemies:
- Stimulus: enemy 0 on a set bit with alive=0; enemy 1 at (200,5).
- Response: enemy_hit=0, no score pulse, score unchanged.
REQ-039 Player collision:
- Stimulus: user (50,60); enemy 3 alive at (50,60); grid all 0.
- Response: health_update pulses once, score_update=0.
REQ-040 Saturation:
- Stimulus: SCORE_W=2, all 4 enemies hit in each of two frames.
- Response: score 0->3, then stays 3.
REQ-041 Overrun and snapshot:
- Stimulus: TICK_COUNT=2, NUM_ENEMIES=4 (tick period 3 < scan length); change enemy_x mid-scan.
- Response: overrun=1 after the second tick; the report reflects the latched positions.
REQ-042 Reset mid-operation:
- Stimulus: assert reset at scan index 2, between clock edges.
- Response: all outputs 0 immediately; no pulse follows; first tick arrives 4 clocks after release.
